// File: rtl/iter_div_axis.sv
// Iterative radix-2 restoring divider with independent AXI-stream operand channels,
// a one-cycle {quotient, remainder} result pulse and a flush to abandon work in flight.
module iter_div_axis #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
  input  logic               s_axis_dividend_tvalid,
  output logic               s_axis_dividend_tready,
  input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic               s_axis_divisor_tvalid,
  output logic               s_axis_divisor_tready,
  output logic [2*WIDTH-1:0] m_axis_dout_tdata,
  output logic               m_axis_dout_tvalid,
  output logic [1:0]         o_dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_dvd_full;
  logic                 r_dvs_full;
  logic [WIDTH-1:0]     r_dvd_data;
  logic [WIDTH-1:0]     r_dvs_data;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH:0]       r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_div;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic                 r_div_zero;
  logic [2*WIDTH-1:0]   r_dout_tdata;
  logic                 r_dout_tvalid;

  logic                 w_dvd_hs;
  logic                 w_dvs_hs;
  logic                 w_start;
  logic [WIDTH-1:0]     w_dvd_op;
  logic [WIDTH-1:0]     w_dvs_op;
  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_shift;
  logic [WIDTH:0]       w_diff;
  logic                 w_keep;
  logic [WIDTH:0]       w_rem_nxt;
  logic [WIDTH-1:0]     w_quo_nxt;
  logic [WIDTH-1:0]     w_q_fin;
  logic [WIDTH-1:0]     w_r_fin;
  logic                 w_last;

  // Valid/ready: a word transfers on a channel in any cycle where tvalid && tready at the
  // rising edge; tready only depends on state/slot registers, never on tvalid.
  assign s_axis_dividend_tready = (r_state == S_IDLE) && !r_dvd_full;
  assign s_axis_divisor_tready  = (r_state == S_IDLE) && !r_dvs_full;
  assign m_axis_dout_tdata      = r_dout_tdata;
  assign m_axis_dout_tvalid     = r_dout_tvalid;
  assign o_dbg_state            = r_state;

  assign w_dvd_hs = s_axis_dividend_tvalid && s_axis_dividend_tready;
  assign w_dvs_hs = s_axis_divisor_tvalid && s_axis_divisor_tready;
  assign w_start  = (r_dvd_full || w_dvd_hs) && (r_dvs_full || w_dvs_hs);

  // The operand arriving this cycle bypasses its slot so BUSY can start on the same edge.
  assign w_dvd_op = r_dvd_full ? r_dvd_data : s_axis_dividend_tdata;
  assign w_dvs_op = r_dvs_full ? r_dvs_data : s_axis_divisor_tdata;
  assign w_sa     = SIGNED ? w_dvd_op[WIDTH-1] : 1'b0;
  assign w_sb     = SIGNED ? w_dvs_op[WIDTH-1] : 1'b0;
  assign w_mag_a  = w_sa ? -w_dvd_op : w_dvd_op;
  assign w_mag_b  = w_sb ? -w_dvs_op : w_dvs_op;

  assign w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_div};
  assign w_keep    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_keep ? w_diff : w_shift;
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_keep};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  // A zero divisor yields all-ones quotient bits and the dividend magnitude as remainder;
  // forcing the quotient keeps it all-ones even when the dividend sign would negate it.
  assign w_q_fin = r_div_zero ? {WIDTH{1'b1}} : (r_q_neg ? -w_quo_nxt : w_quo_nxt);
  assign w_r_fin = r_r_neg ? -w_rem_nxt[WIDTH-1:0] : w_rem_nxt[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_dvd_full    <= 1'b0;
      r_dvs_full    <= 1'b0;
      r_dvd_data    <= '0;
      r_dvs_data    <= '0;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_div         <= '0;
      r_q_neg       <= 1'b0;
      r_r_neg       <= 1'b0;
      r_div_zero    <= 1'b0;
      r_dout_tdata  <= '0;
      r_dout_tvalid <= 1'b0;
    end else if (flush) begin
      r_state       <= S_IDLE;
      r_dvd_full    <= 1'b0;
      r_dvs_full    <= 1'b0;
      r_cnt         <= '0;
      r_dout_tvalid <= 1'b0;
    end else begin
      r_dout_tvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_dvd_hs) begin
            r_dvd_full <= 1'b1;
            r_dvd_data <= s_axis_dividend_tdata;
          end
          if (w_dvs_hs) begin
            r_dvs_full <= 1'b1;
            r_dvs_data <= s_axis_divisor_tdata;
          end
          if (w_start) begin
            r_state    <= S_BUSY;
            r_rem      <= '0;
            r_quo      <= w_mag_a;
            r_div      <= w_mag_b;
            r_q_neg    <= w_sa ^ w_sb;
            r_r_neg    <= w_sa;
            r_div_zero <= (w_dvs_op == '0);
            r_cnt      <= '0;
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state       <= S_DONE;
            r_dout_tdata  <= {w_q_fin, w_r_fin};
            r_dout_tvalid <= 1'b1;
            r_dvd_full    <= 1'b0;
            r_dvs_full    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_axis.sv
// Bench for iter_div_axis: a signed and an unsigned instance share one stimulus stream;
// expected results come from plain integer division and are matched against dout pulses.
module tb_iter_div_axis;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           flush = 1'b0;
  logic [W-1:0]   dvd_data = '0;
  logic [W-1:0]   dvs_data = '0;
  logic           dvd_valid = 1'b0;
  logic           dvs_valid = 1'b0;
  logic           rdy_dvd_u, rdy_dvs_u, vld_u;
  logic           rdy_dvd_s, rdy_dvs_s, vld_s;
  logic [2*W-1:0] dout_u, dout_s;
  logic [1:0]     st_u, st_s;

  int             cyc = 0;
  int             checks = 0;
  int             errors = 0;
  logic [2*W-1:0] exp_u_q[$];
  logic [2*W-1:0] exp_s_q[$];
  int             cyc_u_q[$];
  int             cyc_s_q[$];
  logic [2*W-1:0] last_u = '0;
  logic [2*W-1:0] last_s = '0;
  logic [2*W-1:0] e_u, e_s;
  int             ec_u, ec_s;

  iter_div_axis #(.WIDTH(W), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid),
    .s_axis_dividend_tready(rdy_dvd_u),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid),
    .s_axis_divisor_tready(rdy_dvs_u),
    .m_axis_dout_tdata(dout_u), .m_axis_dout_tvalid(vld_u), .o_dbg_state(st_u)
  );

  iter_div_axis #(.WIDTH(W), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_axis_dividend_tdata(dvd_data), .s_axis_dividend_tvalid(dvd_valid),
    .s_axis_dividend_tready(rdy_dvd_s),
    .s_axis_divisor_tdata(dvs_data), .s_axis_divisor_tvalid(dvs_valid),
    .s_axis_divisor_tready(rdy_dvs_s),
    .m_axis_dout_tdata(dout_s), .m_axis_dout_tvalid(vld_s), .o_dbg_state(st_s)
  );

  // Clock/reset block and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_u(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == 0) return {{W{1'b1}}, a};
    return {a / b, a % b};
  endfunction

  function automatic logic [2*W-1:0] ref_s(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, q, r;
    if (b == 0) return {{W{1'b1}}, a};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {q, r};
  endfunction

  task automatic chk(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Driver: raise dividend valid da cycles and divisor valid db cycles after the call,
  // hold each until its handshake, and return the cycle of the last capture.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input int da,
                       input int db, input bit push, output int n_last);
    bit got_a, got_b;
    int t;
    got_a  = 1'b0;
    got_b  = 1'b0;
    t      = 0;
    n_last = 0;
    if (da == 0) begin dvd_data = a; dvd_valid = 1'b1; end
    if (db == 0) begin dvs_data = b; dvs_valid = 1'b1; end
    while (!(got_a && got_b) && t < 300) begin
      @(negedge clk);
      if (dvd_valid && rdy_dvd_s) begin got_a = 1'b1; n_last = cyc; end
      if (dvs_valid && rdy_dvs_s) begin got_b = 1'b1; n_last = cyc; end
      @(posedge clk);
      #1;
      if (got_a) dvd_valid = 1'b0;
      if (got_b) dvs_valid = 1'b0;
      t++;
      if (t == da && !got_a) begin dvd_data = a; dvd_valid = 1'b1; end
      if (t == db && !got_b) begin dvs_data = b; dvs_valid = 1'b1; end
    end
    checks++;
    if (!(got_a && got_b)) begin
      errors++;
      $display("FAIL handshake_timeout: got dvd=%0d dvs=%0d, required both accepted", got_a, got_b);
      dvd_valid = 1'b0;
      dvs_valid = 1'b0;
    end else if (push) begin
      exp_u_q.push_back(ref_u(a, b));
      exp_s_q.push_back(ref_s(a, b));
      cyc_u_q.push_back(n_last + LAT);
      cyc_s_q.push_back(n_last + LAT);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_u_q.size() != 0 || exp_s_q.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    checks++;
    if (exp_u_q.size() != 0 || exp_s_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d results outstanding, required 0", exp_u_q.size(), exp_s_q.size());
      exp_u_q.delete(); exp_s_q.delete(); cyc_u_q.delete(); cyc_s_q.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      4:       return W'($urandom_range(0, 20));
      5:       return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: every dout pulse must match the oldest expectation and its cycle.
  always @(negedge clk) begin
    if (vld_u) begin
      checks++;
      if (exp_u_q.size() == 0) begin
        errors++;
        $display("FAIL udiv_pulse: got unexpected pulse tdata=%h, required none (cycle %0d)", dout_u, cyc);
      end else begin
        e_u  = exp_u_q.pop_front();
        ec_u = cyc_u_q.pop_front();
        chk("udiv_data", dout_u, e_u);
        chk("udiv_cycle", 64'(cyc), 64'(ec_u));
        last_u = e_u;
      end
    end
    if (vld_s) begin
      checks++;
      if (exp_s_q.size() == 0) begin
        errors++;
        $display("FAIL sdiv_pulse: got unexpected pulse tdata=%h, required none (cycle %0d)", dout_s, cyc);
      end else begin
        e_s  = exp_s_q.pop_front();
        ec_s = cyc_s_q.pop_front();
        chk("sdiv_data", dout_s, e_s);
        chk("sdiv_cycle", 64'(cyc), 64'(ec_s));
        last_s = e_s;
      end
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_rdy"}, {60'b0, rdy_dvd_u, rdy_dvs_u, rdy_dvd_s, rdy_dvs_s}, 64'hF);
    chk({tag, "_vld"}, {62'b0, vld_u, vld_s}, 64'h0);
    chk({tag, "_state"}, {60'b0, st_u, st_s}, 64'h0);
  endtask

  initial begin
    int n, n1, n2;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk_idle("reset");
    chk("reset_dout_u", dout_u, 64'h0);
    chk("reset_dout_s", dout_s, 64'h0);
    @(posedge clk);
    #1;

    issue(32'd100, 32'd7, 0, 0, 1'b1, n);
    issue(-32'sd7, 32'd2, 0, 3, 1'b1, n);
    issue(32'd7, -32'sd2, 2, 0, 1'b1, n);
    issue(32'h1234_5678, 32'h0, 0, 0, 1'b1, n);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 1, 1'b1, n);
    drain();

    // Flush ten cycles into a divide: no pulse, operands dropped, dout held.
    issue(32'd1000, 32'd3, 0, 0, 1'b0, n);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_cycle", 64'(cyc), 64'(n + 11));
    chk_idle("flush");
    chk("flush_hold_u", dout_u, last_u);
    chk("flush_hold_s", dout_s, last_s);
    repeat (30) @(posedge clk);
    #1;
    issue(32'd9, 32'd3, 0, 0, 1'b1, n);
    drain();

    // Reset in the middle of BUSY: no pulse, outputs cleared.
    issue(32'd50, 32'd5, 0, 0, 1'b0, n);
    repeat (10) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk_idle("midreset");
    chk("midreset_dout_u", dout_u, 64'h0);
    chk("midreset_dout_s", dout_s, 64'h0);
    last_u = '0;
    last_s = '0;
    repeat (40) @(posedge clk);
    #1;

    // Operands held valid while busy are accepted right after the DONE pulse.
    issue(-32'sd100, 32'd9, 0, 0, 1'b1, n1);
    issue(32'd77, 32'd11, 0, 0, 1'b1, n2);
    chk("held_accept", 64'(n2), 64'(n1 + LAT + 1));
    drain();

    for (int i = 0; i < 40; i++) begin
      issue(pick(), pick(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1, n);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
